// File: rtl/window_buffer.sv
// Streaming 3x3 neighbourhood generator: two circular line buffers feed a shifting
// 3x3 register array; each step emits one edge-masked window centred one line plus one pixel back.
module window_buffer #(
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned IMG_WIDTH   = 320,
    parameter int unsigned IMG_HEIGHT  = 240
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIXEL_WIDTH-1:0]   in_pixel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [9*PIXEL_WIDTH-1:0] win_out,
    output logic [9:0]               x_out,
    output logic [9:0]               y_out,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     frame_done
);

    localparam int unsigned AddrW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0]  XLast = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]  YLast = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0]  Lead  = 10'(IMG_WIDTH);

    typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

    state_e                 state_q;
    logic [9:0]             in_x_q, in_y_q, out_x_q, out_y_q, cnt_q;
    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] arr_q [3][3];
    logic [PIXEL_WIDTH-1:0] col_new [3];
    logic [9*PIXEL_WIDTH-1:0] win_next;
    logic [PIXEL_WIDTH-1:0] step_pix;
    logic [9:0]             step_x;
    logic [AddrW-1:0]       lb_addr;
    logic                   out_free, accept, step, load, last_in;

    always_comb begin
        out_free = !win_valid || win_ready;
        in_ready = 1'b0;
        unique case (state_q)
            StFill:  in_ready = 1'b1;
            StRun:   in_ready = out_free;
            StFlush: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
        accept   = in_valid && in_ready;
        step     = accept || (state_q == StFlush && out_free);
        load     = (state_q == StRun && accept) || (state_q == StFlush && out_free);
        last_in  = (in_x_q == XLast) && (in_y_q == YLast);
        step_pix = (state_q == StFlush) ? '0 : in_pixel;
        // Phantom steps keep walking the line-buffer address from x=0 of the next frame
        step_x   = (state_q == StFlush) ? ((cnt_q == Lead) ? '0 : cnt_q) : in_x_q;
        lb_addr  = step_x[AddrW-1:0];
        col_new[0] = lb1[lb_addr];
        col_new[1] = lb0[lb_addr];
        col_new[2] = step_pix;
    end

    // Window as it will look after this step's column shift, with out-of-image taps zeroed
    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((c == 0 && out_x_q == 10'd0) || (c == 2 && out_x_q == XLast) ||
                      (r == 0 && out_y_q == 10'd0) || (r == 2 && out_y_q == YLast))) begin
                    win_next[(r*3+c)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                        (c < 2) ? arr_q[r][c+1] : col_new[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            lb1[lb_addr] <= lb0[lb_addr];
            lb0[lb_addr] <= step_pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFill;
            in_x_q     <= '0;
            in_y_q     <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            cnt_q      <= '0;
            win_out    <= '0;
            x_out      <= '0;
            y_out      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    arr_q[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= win_valid && win_ready && (x_out == XLast) && (y_out == YLast);

            if (step) begin
                for (int r = 0; r < 3; r++) begin
                    arr_q[r][0] <= arr_q[r][1];
                    arr_q[r][1] <= arr_q[r][2];
                    arr_q[r][2] <= col_new[r];
                end
            end

            if (load) begin
                win_out   <= win_next;
                x_out     <= out_x_q;
                y_out     <= out_y_q;
                win_valid <= 1'b1;
                if (out_x_q == XLast) begin
                    out_x_q <= '0;
                    out_y_q <= (out_y_q == YLast) ? '0 : out_y_q + 10'd1;
                end else begin
                    out_x_q <= out_x_q + 10'd1;
                end
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end

            if (accept) begin
                if (in_x_q == XLast) begin
                    in_x_q <= '0;
                    in_y_q <= (in_y_q == YLast) ? '0 : in_y_q + 10'd1;
                end else begin
                    in_x_q <= in_x_q + 10'd1;
                end
            end

            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        if (cnt_q == Lead) begin
                            state_q <= StRun;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                end
                StRun: begin
                    if (accept && last_in) begin
                        state_q <= StFlush;
                        cnt_q   <= '0;
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        if (cnt_q == Lead) begin
                            state_q <= StFill;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: doc/window_buffer.md
# window_buffer

Streaming 3x3 neighbourhood generator that sits directly upstream of the superresolution core. It accepts raster-order RGB pixels from the frame source and buffers two image lines in internal RAM. For every input pixel it emits one 3x3 window centred on that pixel, with out-of-image taps forced to zero, plus the centre coordinates. The superresolution core consumes the window as its neighbourhood and the coordinates as `x_in`/`y_in`.

## Interface
- `PIXEL_WIDTH`, 24: bits per pixel (packed RGB888).
- `IMG_WIDTH`, 320: pixels per line; legal range 4..1023.
- `IMG_HEIGHT`, 240: lines per frame; legal range 3..1023.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_pixel` in PIXEL_WIDTH: input pixel, raster order.
- `in_valid` in 1: `in_pixel` is valid.
- `in_ready` out 1: the block accepts `in_pixel` this cycle.
- `win_out` out 9*PIXEL_WIDTH: window taps; tap n occupies `[n*PIXEL_WIDTH +: PIXEL_WIDTH]`. Taps are row-major, tap 0 is (x-1,y-1), tap 4 is the centre, tap 8 is (x+1,y+1).
- `x_out` out 10: centre x coordinate.
- `y_out` out 10: centre y coordinate.
- `win_valid` out 1: the window and coordinates are valid.
- `win_ready` in 1: the consumer takes the window this cycle.
- `frame_done` out 1: one-cycle pulse when the window at (IMG_WIDTH-1, IMG_HEIGHT-1) is transferred.

## Operation
- Storage:
  - Two line buffers, each IMG_WIDTH x PIXEL_WIDTH, organised as circular RAM indexed by input x.
  - A 3x3 register array that shifts one column per step.
- Step: one pixel enters the array. It is either the accepted input pixel or, in FLUSH, a phantom zero pixel. Pixel index k drives the window centred on index k-(IMG_WIDTH+1).
- Counters: input (x,y) and output (x,y). Each wraps x at IMG_WIDTH-1 to 0 and increments y; y wraps at IMG_HEIGHT-1 to 0.
- Masking, applied when the output register is loaded:
  - Left column taps are zero when x_out=0.
  - Right column taps are zero when x_out=IMG_WIDTH-1.
  - Top row taps are zero when y_out=0.
  - Bottom row taps are zero when y_out=IMG_HEIGHT-1.
- Because of masking, line-buffer contents are never reset. Stale data from the previous frame never appears in a window.
- FSM states, with FILL as the reset state:
  - FILL: `in_ready`=1. Each accepted pixel performs a step and produces no window. After IMG_WIDTH+1 accepted pixels, go to RUN.
  - RUN: `in_ready` = !`win_valid` | `win_ready`. Each accepted pixel performs a step and loads the output register. When the last pixel of the frame (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted, go to FLUSH.
  - FLUSH: `in_ready`=0. Whenever !`win_valid` | `win_ready`, perform a phantom step and load the output register. After IMG_WIDTH+1 phantom steps, go to FILL.
- Output register:
  - Holds `win_out`, `x_out` and `y_out`.
  - It is stable while `win_valid` & !`win_ready`.
  - `win_valid` is set on load. It is cleared when a transfer occurs with no new load in the same cycle.
- Simultaneous transfer and load in RUN/FLUSH: the new window replaces the old one and `win_valid` stays 1. This gives no bubble at full throughput.
- FILL of the next frame may proceed while the final window of the previous frame is still held. FILL does not touch the output register.
- Frame count invariant: windows emitted per frame = IMG_WIDTH*IMG_HEIGHT.

## Timing
- Reset values:
  - `in_ready`=1 (FILL).
  - `win_valid`=0, `frame_done`=0.
  - `win_out`=0, `x_out`=0, `y_out`=0.
  - All counters and FSM state are cleared.
- Reset mid-frame: the partial frame is discarded. The first pixel accepted after `rst` deasserts is treated as (0,0).
- Latency: `win_valid` for window (0,0) rises the cycle after the edge that accepts input pixel index IMG_WIDTH+1.
- Throughput: one window per clock in RUN with continuous `in_valid` and `win_ready`.
- `frame_done` asserts the cycle after the transfer edge of the last window. It lasts exactly one cycle.
- `in_ready` depends combinationally on `win_ready`. No other combinational input-to-output paths exist.

## Test plan
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=3; pixel (x,y) has value y*4+x+1.

- Full frame with `win_ready`=1 and continuous input: the 12 windows come out in raster order.
  - (0,0) = [0,0,0, 0,1,2, 0,5,6]
  - (1,1) = [1,2,3, 5,6,7, 9,10,11]
  - (3,2) = [7,8,0, 11,12,0, 0,0,0]
  - `frame_done` pulses once.
- Latency check: the first `win_valid` appears the cycle after the 6th input accept. `in_ready` is 0 for exactly 5 FLUSH steps.
- Backpressure: hold `win_ready`=0 for 10 cycles mid-frame. Required: `win_out`, `x_out`, `y_out` stay stable; `in_ready`=0; no windows are lost or duplicated, so the count is 12.
- Random `in_valid` and `win_ready` gaps across two back-to-back frames, with frame 2 values offset by +100: every frame-2 window matches the reference. No frame-1 data appears in y=0 taps.
- `rst` pulsed after 7 accepts, mid-RUN: all outputs return to reset values. A following full frame produces the same 12 windows as the first scenario.
